// File: rtl/spi_ram_pkg.sv
// Shared encodings for the SPI/host RAM arbiter:
// SPI command codes, arbiter states and access owner tags.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_SPI  = 1'b0,
        OWNER_HOST = 1'b1
    } owner_e;

    // Frames that queue a RAM access (as opposed to loading an address latch).
    function automatic logic is_access(input logic [1:0] cmd);
        return (cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA);
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Bundle of SPI frame, host port and RAM port signals.
// slave = arbiter side, master = environment side.
interface spi_ram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();
    logic [DATA_WIDTH+1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  host_rvalid;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  spi_overrun;

    modport slave (
        input  rx_data, rx_valid, host_req, host_we, host_addr,
        input  host_wdata, ram_rdata,
        output tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata, spi_overrun
    );

    modport master (
        output rx_data, rx_valid, host_req, host_we, host_addr,
        output host_wdata, ram_rdata,
        input  tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata, spi_overrun
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI frame decoder: address latches, optional auto-increment,
// single-entry pending access snapshot and sticky overrun flag.
module spi_cmd_decoder
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter bit AUTO_INC   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH+1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  grant,
    output logic                  pend_valid,
    output logic                  pend_we,
    output logic [ADDR_WIDTH-1:0] pend_addr,
    output logic [DATA_WIDTH-1:0] pend_data,
    output logic                  spi_overrun
);
    logic [1:0]            cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_we_q, pend_we_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  overrun_q, overrun_d;

    assign cmd     = rx_data[DATA_WIDTH+1:DATA_WIDTH];
    assign payload = rx_data[DATA_WIDTH-1:0];

    // Latch updates, snapshot of a new access, drop-on-busy detection.
    always_comb begin
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        pend_valid_d = pend_valid_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        overrun_d    = overrun_q;
        if (grant) begin
            pend_valid_d = 1'b0;
            if (AUTO_INC) begin
                if (pend_we_q) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                else           rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            end
        end
        if (rx_valid) begin
            if (cmd == CMD_WR_ADDR) wr_addr_d = payload[ADDR_WIDTH-1:0];
            if (cmd == CMD_RD_ADDR) rd_addr_d = payload[ADDR_WIDTH-1:0];
            if (is_access(cmd)) begin
                if (pend_valid_q && !grant) begin
                    overrun_d = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_we_d    = (cmd == CMD_WR_DATA);
                    pend_addr_d  = (cmd == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;
                    pend_data_d  = payload;
                end
            end
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            pend_valid_q <= pend_valid_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pend_valid  = pend_valid_q;
    assign pend_we     = pend_we_q;
    assign pend_addr   = pend_addr_q;
    assign pend_data   = pend_data_q;
    assign spi_overrun = overrun_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between the SPI command stream and a host port.
// SPI wins ties; read data is steered back to the owner of the access.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter bit AUTO_INC   = 1'b0
) (
    input logic               clk,
    input logic               rst,
    spi_ram_arbiter_if.slave  bus
);
    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  host_gnt_q, host_gnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  host_rvalid_q, host_rvalid_d;
    logic                  spi_grant;
    logic                  pend_valid;
    logic                  pend_we;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0] pend_data;
    logic                  spi_overrun;

    spi_cmd_decoder #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .AUTO_INC   (AUTO_INC)
    ) u_dec (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (bus.rx_data),
        .rx_valid    (bus.rx_valid),
        .grant       (spi_grant),
        .pend_valid  (pend_valid),
        .pend_we     (pend_we),
        .pend_addr   (pend_addr),
        .pend_data   (pend_data),
        .spi_overrun (spi_overrun)
    );

    // Arbitration, RAM command staging and read-data steering.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = '0;
        ram_wdata_d   = '0;
        host_gnt_d    = 1'b0;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        spi_grant     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_valid) begin
                    spi_grant   = 1'b1;
                    state_d     = ST_ACCESS;
                    owner_d     = OWNER_SPI;
                    ram_en_d    = 1'b1;
                    ram_we_d    = pend_we;
                    ram_addr_d  = pend_addr;
                    ram_wdata_d = pend_we ? pend_data : '0;
                end else if (bus.host_req) begin
                    state_d     = ST_ACCESS;
                    owner_d     = OWNER_HOST;
                    host_gnt_d  = 1'b1;
                    ram_en_d    = 1'b1;
                    ram_we_d    = bus.host_we;
                    ram_addr_d  = bus.host_addr;
                    ram_wdata_d = bus.host_we ? bus.host_wdata : '0;
                end
            end
            ST_ACCESS: begin
                state_d = ram_we_q ? ST_IDLE : ST_RD_DATA;
            end
            ST_RD_DATA: begin
                state_d = ST_IDLE;
                if (owner_q == OWNER_SPI) begin
                    tx_data_d  = bus.ram_rdata;
                    tx_valid_d = 1'b1;
                end else begin
                    host_rdata_d  = bus.ram_rdata;
                    host_rvalid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_SPI;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            host_gnt_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            host_gnt_q    <= host_gnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.host_gnt    = host_gnt_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.spi_overrun = spi_overrun;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter (AUTO_INC=1): directed SPI/host traffic,
// a scheduling model compared every cycle, and literal spot checks.
module tb_spi_ram_arbiter;
    import spi_ram_pkg::*;

    localparam bit AI = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    spi_ram_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .AUTO_INC   (AI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural single-port RAM: read data one cycle after ram_en.
    logic [7:0] mem [256];
    bit         ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
            ram_init = 1'b1;
        end
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    // Model: busy counter for RAM occupancy, read return countdown.
    logic [7:0] m_mem [256];
    bit         started = 1'b0;
    int         m_busy, m_ret_cnt;
    bit         m_pv, m_pwe, m_ovr, m_ret_spi;
    logic [7:0] m_paddr, m_pdata, m_wr, m_rd, m_ret_data;
    bit         idle, gs, gh, m_we;
    logic [7:0] m_a, m_d, pl;
    bit         e_en, e_we, e_gnt, e_txv, e_hv;
    logic [7:0] e_addr, e_wdata, e_txd, e_hd;

    always @(posedge clk) begin
        if (!started) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;
            started = 1'b1;
        end
        e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        e_gnt = 0; e_txv = 0; e_hv = 0;
        if (rst) begin
            m_busy = 0; m_ret_cnt = 0; m_pv = 0; m_pwe = 0; m_ovr = 0;
            m_paddr = 0; m_pdata = 0; m_wr = 0; m_rd = 0;
            e_txd = 0; e_hd = 0;
        end else begin
            if (m_ret_cnt > 0) begin
                m_ret_cnt--;
                if (m_ret_cnt == 0) begin
                    if (m_ret_spi) begin e_txv = 1; e_txd = m_ret_data; end
                    else begin e_hv = 1; e_hd = m_ret_data; end
                end
            end
            idle = (m_busy == 0);
            if (!idle) m_busy--;
            gs = idle && m_pv;
            gh = idle && !m_pv && bus.host_req;
            if (gs || gh) begin
                m_we = gs ? m_pwe : bus.host_we;
                m_a  = gs ? m_paddr : bus.host_addr;
                m_d  = gs ? m_pdata : bus.host_wdata;
                e_en = 1; e_we = m_we; e_addr = m_a;
                e_wdata = m_we ? m_d : 8'h00;
                e_gnt = gh;
                if (m_we) begin
                    m_mem[m_a] = m_d;
                    m_busy = 1;
                end else begin
                    m_busy = 2;
                    m_ret_cnt = 2;
                    m_ret_spi = gs;
                    m_ret_data = m_mem[m_a];
                end
                if (gs) begin
                    m_pv = 0;
                    if (AI) begin
                        if (m_pwe) m_wr++;
                        else       m_rd++;
                    end
                end
            end
            if (bus.rx_valid) begin
                pl = bus.rx_data[7:0];
                case (bus.rx_data[9:8])
                    2'b00: m_wr = pl;
                    2'b10: m_rd = pl;
                    default: begin
                        if (m_pv) m_ovr = 1;
                        else begin
                            m_pv = 1;
                            m_pwe = (bus.rx_data[9:8] == 2'b01);
                            m_paddr = m_pwe ? m_wr : m_rd;
                            m_pdata = pl;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [37:0] outs();
        return {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                bus.host_gnt, bus.host_rvalid, bus.host_rdata,
                bus.tx_valid, bus.tx_data, bus.spi_overrun};
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            n_vec++;
            if (outs() !== {e_en, e_we, e_addr, e_wdata, e_gnt, e_hv, e_hd,
                            e_txv, e_txd, m_ovr}) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t got=%h expected=%h", $time, outs(),
                         {e_en, e_we, e_addr, e_wdata, e_gnt, e_hv, e_hd,
                          e_txv, e_txd, m_ovr});
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] p);
        bus.rx_data  = {cmd, p};
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
    endtask

    // Holds host_req until the grant is seen; returns negedges waited.
    task automatic host_access(input logic we, input logic [7:0] a,
                               input logic [7:0] d, output int waited);
        bit got;
        got = 0;
        waited = 0;
        bus.host_req = 1'b1; bus.host_we = we;
        bus.host_addr = a;   bus.host_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            waited = i + 1;
            if (bus.host_gnt) got = 1;
        end
        bus.host_req = 1'b0;
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL host_gnt_timeout: got none, expected grant in 20");
        end
    endtask

    int w;

    initial begin
        bus.rx_data = '0; bus.rx_valid = 0; bus.host_req = 0;
        bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.ram_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'(outs()), 64'd0);
        rst = 1'b0;

        send(CMD_WR_ADDR, 8'h12);
        send(CMD_WR_DATA, 8'hAB);
        send(CMD_RD_ADDR, 8'h12);
        send(CMD_RD_DATA, 8'h00);
        repeat (3) @(negedge clk);
        chk("spi_read_tx", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hAB});
        chk("spi_write_mem", mem[8'h12], 8'hAB);
        repeat (3) @(negedge clk);

        host_access(1'b1, 8'h20, 8'h55, w);
        host_access(1'b0, 8'h20, 8'h00, w);
        repeat (2) @(negedge clk);
        chk("host_read", {bus.host_rvalid, bus.host_rdata}, {1'b1, 8'h55});

        send(CMD_WR_ADDR, 8'h30);
        send(CMD_WR_DATA, 8'h77);
        host_access(1'b1, 8'h31, 8'h66, w);
        chk("spi_first_wait", w, 3);
        @(negedge clk);
        chk("tie_spi_mem", mem[8'h30], 8'h77);
        chk("tie_host_mem", mem[8'h31], 8'h66);

        host_access(1'b0, 8'h20, 8'h00, w);
        send(CMD_WR_DATA, 8'h01);
        send(CMD_WR_DATA, 8'h02);
        chk("busy_host_read", {bus.host_rvalid, bus.host_rdata}, {1'b1, 8'h55});
        chk("overrun_set", bus.spi_overrun, 1);
        repeat (6) @(negedge clk);
        chk("overrun_sticky", bus.spi_overrun, 1);
        chk("first_frame_mem", mem[8'h31], 8'h01);

        send(CMD_WR_ADDR, 8'hFF);
        send(CMD_WR_DATA, 8'hC1);
        repeat (3) @(negedge clk);
        send(CMD_WR_DATA, 8'hC2);
        repeat (4) @(negedge clk);
        chk("wrap_mem_ff", mem[8'hFF], 8'hC1);
        chk("wrap_mem_00", mem[8'h00], 8'hC2);

        send(CMD_RD_ADDR, 8'h30);
        send(CMD_RD_DATA, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_rd", 64'(outs()), 64'd0);
        rst = 1'b0;
        send(CMD_RD_ADDR, 8'h12);
        send(CMD_RD_DATA, 8'h00);
        repeat (3) @(negedge clk);
        chk("read_after_rst", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hAB});
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
